// File: rtl/weight_column_encoder_if.sv
// rtl/weight_column_encoder_if.sv - weight tile intake and MAC control bundle
// master = tile source / MAC side, slave = encoder.
interface weight_column_encoder_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 32,
  parameter int MUX_SEL_WIDTH = 3,
  parameter int COL_WIDTH     = $clog2(DATA_WIDTH)
);
  logic                         w_valid;
  logic                         w_ready;
  logic signed [DATA_WIDTH-1:0] w_in [VEC_LENGTH];
  logic                         mac_stall;
  logic [MUX_SEL_WIDTH-1:0]     act_sel [VEC_LENGTH/2];
  logic [VEC_LENGTH/2-1:0]      act_val;
  logic [VEC_LENGTH/8-1:0]      is_skip_zero;
  logic [COL_WIDTH-1:0]         column_idx;
  logic                         is_msb;
  logic                         en_acc;
  logic                         load_accum;
  logic                         busy;
  logic                         done;

  modport master (
    output w_valid, w_in, mac_stall,
    input  w_ready, act_sel, act_val, is_skip_zero, column_idx, is_msb,
           en_acc, load_accum, busy, done
  );

  modport slave (
    input  w_valid, w_in, mac_stall,
    output w_ready, act_sel, act_val, is_skip_zero, column_idx, is_msb,
           en_acc, load_accum, busy, done
  );
endinterface

// File: rtl/weight_column_encoder.sv
// rtl/weight_column_encoder.sv - bit-serial weight column encoder for the no-multiplier MAC
// Outputs always show the column emitted at the last unstalled edge; col is the column on display.
module weight_column_encoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 32,
  parameter int MUX_SEL_WIDTH = 3,
  parameter int COL_WIDTH     = $clog2(DATA_WIDTH)
) (
  input logic clk,
  input logic reset,
  weight_column_encoder_if.slave bus
);
  localparam int GROUPS = VEC_LENGTH / 8;
  localparam int MUXES  = VEC_LENGTH / 2;
  localparam logic [COL_WIDTH-1:0] MSB_COL = COL_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  typedef struct packed {
    logic                          sz;
    logic [3:0]                    val;
    logic [3:0][MUX_SEL_WIDTH-1:0] sel;
  } grp_enc_t;

  state_t                       state;
  logic [COL_WIDTH-1:0]         col;
  logic                         first_emit;
  logic signed [DATA_WIDTH-1:0] w_reg [VEC_LENGTH];

  logic                     accept;
  logic [COL_WIDTH-1:0]     next_col;
  logic [7:0]               col_bits [GROUPS];
  grp_enc_t                 enc;
  logic [MUX_SEL_WIDTH-1:0] nxt_sel [MUXES];
  logic [MUXES-1:0]         nxt_val;
  logic [GROUPS-1:0]        nxt_sz;
  logic                     inv_ok;

  // Encode the minority value of a group column; greedy lowest-legal-mux assignment.
  function automatic grp_enc_t encode_group(input logic [7:0] grp);
    grp_enc_t   r;
    logic [7:0] code;
    int         n1;
    int         prev;
    int         m;
    r    = '0;
    n1   = 0;
    prev = -1;
    for (int p = 0; p < 8; p++) n1 += int'(grp[p]);
    r.sz = (n1 <= 4);
    code = r.sz ? grp : ~grp;
    for (int p = 0; p < 8; p++) begin
      if (code[p]) begin
        m = (prev + 1 > p - 4) ? prev + 1 : p - 4;
        if (m <= 3) begin
          r.sel[m[1:0]] = MUX_SEL_WIDTH'(p - m);
          r.val[m[1:0]] = 1'b1;
        end
        prev = m;
      end
    end
    return r;
  endfunction

  assign accept   = (state == IDLE) && bus.w_valid && bus.w_ready;
  assign next_col = accept ? MSB_COL : col - COL_WIDTH'(1);

  // The first column is encoded straight from w_in so it appears the cycle after accept.
  always_comb begin
    for (int g = 0; g < GROUPS; g++) begin
      for (int b = 0; b < 8; b++) begin
        col_bits[g][b] = accept ? bus.w_in[8*g+b][next_col] : w_reg[8*g+b][next_col];
      end
    end
  end

  always_comb begin
    enc     = '0;
    nxt_val = '0;
    nxt_sz  = '0;
    for (int k = 0; k < MUXES; k++) nxt_sel[k] = '0;
    for (int g = 0; g < GROUPS; g++) begin
      enc       = encode_group(col_bits[g]);
      nxt_sz[g] = enc.sz;
      for (int m = 0; m < 4; m++) begin
        nxt_sel[4*g+m] = enc.sel[m];
        nxt_val[4*g+m] = enc.val[m];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      col              <= '0;
      first_emit       <= 1'b0;
      bus.w_ready      <= 1'b0;
      bus.act_val      <= '0;
      bus.is_skip_zero <= '0;
      bus.column_idx   <= '0;
      bus.is_msb       <= 1'b0;
      bus.en_acc       <= 1'b0;
      bus.load_accum   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      for (int k = 0; k < MUXES; k++) bus.act_sel[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.w_ready <= 1'b1;
          if (accept) begin
            w_reg            <= bus.w_in;
            state            <= STREAM;
            col              <= next_col;
            first_emit       <= 1'b1;
            bus.w_ready      <= 1'b0;
            bus.busy         <= 1'b1;
            bus.en_acc       <= 1'b1;
            bus.load_accum   <= 1'b0;
            bus.act_sel      <= nxt_sel;
            bus.act_val      <= nxt_val;
            bus.is_skip_zero <= nxt_sz;
            bus.column_idx   <= next_col;
            bus.is_msb       <= (next_col == MSB_COL);
          end
        end
        STREAM: begin
          if (bus.mac_stall) begin
            bus.en_acc     <= 1'b0;
            bus.load_accum <= 1'b0;
          end else begin
            first_emit     <= 1'b0;
            bus.load_accum <= first_emit;
            bus.en_acc     <= 1'b1;
            if (col == '0) begin
              state          <= FLUSH;
              bus.act_val    <= '0;
              bus.column_idx <= '0;
              bus.is_msb     <= 1'b0;
              for (int k = 0; k < MUXES; k++) bus.act_sel[k] <= '0;
            end else begin
              col              <= next_col;
              bus.act_sel      <= nxt_sel;
              bus.act_val      <= nxt_val;
              bus.is_skip_zero <= nxt_sz;
              bus.column_idx   <= next_col;
              bus.is_msb       <= (next_col == MSB_COL);
            end
          end
        end
        FLUSH: begin
          bus.en_acc     <= 1'b0;
          bus.load_accum <= 1'b0;
          if (!bus.mac_stall) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          bus.done    <= 1'b0;
          bus.w_ready <= 1'b1;
        end
      endcase
    end
  end

  // Selects stay inside the 5-wide window and valid muxes never alias a position.
  always_comb begin
    inv_ok = 1'b1;
    for (int g = 0; g < GROUPS; g++) begin
      for (int a = 0; a < 4; a++) begin
        if (bus.act_val[4*g+a] && bus.act_sel[4*g+a] > MUX_SEL_WIDTH'(4)) inv_ok = 1'b0;
        for (int b = a + 1; b < 4; b++) begin
          if (bus.act_val[4*g+a] && bus.act_val[4*g+b] &&
              (a + int'(bus.act_sel[4*g+a]) == b + int'(bus.act_sel[4*g+b])))
            inv_ok = 1'b0;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) inv_ok);
endmodule

// File: tb/tb_weight_column_encoder.sv
// tb/tb_weight_column_encoder.sv - self-checking bench for weight_column_encoder
module tb_weight_column_encoder;
  localparam int DW  = 8;
  localparam int VL  = 32;
  localparam int MSW = 3;
  localparam int NG  = VL / 8;
  localparam int NM  = VL / 2;

  typedef logic [VL-1:0][DW-1:0] tile_t;

  typedef struct {
    tile_t          w;
    int             stall_col;
    int             stall_len;
    bit             const_chk;
    logic [NG-1:0]  exp_sz;
    logic [NM-1:0]  exp_val;
    bit             col0_chk;
    logic [NG-1:0]  exp_sz0;
    logic [3:0]     exp_val0;
    logic [11:0]    exp_sel0;
    int             exp_done;
  } vec_t;

  // ctrl = {w_ready, busy, en_acc, load_accum, is_msb, done, column_idx}; kind 0 col, 1 flush, 2 done, 3 idle
  typedef struct {
    logic [8:0] ctrl;
    int         kind;
    int         col;
    bit         stall;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  weight_column_encoder_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .MUX_SEL_WIDTH(MSW)) bus ();

  weight_column_encoder #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .MUX_SEL_WIDTH(MSW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_now();
    return {bus.w_ready, bus.busy, bus.en_acc, bus.load_accum, bus.is_msb, bus.done, bus.column_idx};
  endfunction

  function automatic logic [3*NM-1:0] sel_now();
    logic [3*NM-1:0] s;
    for (int k = 0; k < NM; k++) s[3*k +: 3] = bus.act_sel[k];
    return s;
  endfunction

  // Reference: per group, list the minority-value positions and place each on the lowest legal mux.
  function automatic void model_col(input tile_t w, input int b, output logic [NG-1:0] sz,
                                    output logic [NM-1:0] val, output logic [3*NM-1:0] sel);
    int pos[$];
    int n1, prev, m;
    sz = '0; val = '0; sel = '0;
    for (int g = 0; g < NG; g++) begin
      pos.delete();
      n1 = 0;
      for (int p = 0; p < 8; p++) n1 += int'(w[8*g+p][b]);
      sz[g] = (n1 <= 4);
      for (int p = 0; p < 8; p++) if (w[8*g+p][b] == sz[g]) pos.push_back(p);
      prev = -1;
      foreach (pos[i]) begin
        m = (pos[i] - 4 > prev + 1) ? pos[i] - 4 : prev + 1;
        val[4*g+m] = 1'b1;
        sel[3*(4*g+m) +: 3] = 3'(pos[i] - m);
        prev = m;
      end
    end
  endfunction

  function automatic vec_t mk(input tile_t w, input int sc, input int sl, input bit cc,
                              input logic [3:0] esz, input logic [15:0] ev, input bit c0,
                              input logic [3:0] esz0, input logic [3:0] ev0, input logic [11:0] es0);
    vec_t v;
    v.w = w; v.stall_col = sc; v.stall_len = sl;
    v.const_chk = cc; v.exp_sz = esz; v.exp_val = ev;
    v.col0_chk = c0; v.exp_sz0 = esz0; v.exp_val0 = ev0; v.exp_sel0 = es0;
    v.exp_done = 10 + sl;
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!bus.w_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, " w_ready"}, 128'(bus.w_ready), 128'(1'b1));
  endtask

  task automatic run_tile(input vec_t v, input string tag);
    cyc_t            tl[$];
    cyc_t            c;
    int              emits;
    int              done_at;
    logic [NG-1:0]   m_sz;
    logic [NM-1:0]   m_val;
    logic [3*NM-1:0] m_sel;
    emits = 0;
    for (int col = DW - 1; col >= 0; col--) begin
      c.ctrl = {1'b0, 1'b1, 1'b1, (emits == 1), (col == DW - 1), 1'b0, 3'(col)};
      c.kind = 0; c.col = col; c.stall = 1'b0;
      tl.push_back(c);
      emits++;
      if (col == v.stall_col) begin
        for (int s = 0; s < v.stall_len; s++) begin
          c.ctrl[6] = 1'b0; c.ctrl[5] = 1'b0; c.stall = 1'b1;
          tl.push_back(c);
        end
      end
    end
    c.ctrl = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}; c.kind = 1; c.col = 0; c.stall = 1'b0;
    tl.push_back(c);
    c.ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}; c.kind = 2;
    tl.push_back(c);
    c.ctrl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; c.kind = 3;
    tl.push_back(c);

    wait_ready(tag);
    bus.w_valid   = 1'b1;
    bus.mac_stall = 1'b0;
    for (int i = 0; i < VL; i++) bus.w_in[i] = v.w[i];
    done_at = -1;
    for (int k = 0; k < tl.size(); k++) begin
      @(negedge clk);
      bus.w_valid = 1'b0;
      check($sformatf("%s ctrl c%0d", tag, k + 1), 128'(ctrl_now()), 128'(tl[k].ctrl));
      if (bus.done && done_at < 0) done_at = k + 1;
      if (tl[k].kind == 0) begin
        model_col(v.w, tl[k].col, m_sz, m_val, m_sel);
        check($sformatf("%s act c%0d", tag, k + 1),
              128'({bus.is_skip_zero, bus.act_val, sel_now()}), 128'({m_sz, m_val, m_sel}));
        if (v.const_chk)
          check($sformatf("%s const c%0d", tag, k + 1),
                128'({bus.is_skip_zero, bus.act_val}), 128'({v.exp_sz, v.exp_val}));
        if (v.col0_chk && tl[k].col == 0)
          check($sformatf("%s col0", tag), 128'({bus.is_skip_zero, bus.act_val[3:0], sel_now()[11:0]}),
                128'({v.exp_sz0, v.exp_val0, v.exp_sel0}));
      end else if (tl[k].kind == 1) begin
        check($sformatf("%s flush act_val", tag), 128'(bus.act_val), 128'(0));
      end
      bus.mac_stall = (k + 1 < tl.size()) ? tl[k+1].stall : 1'b0;
    end
    bus.mac_stall = 1'b0;
    check($sformatf("%s done cycle", tag), 128'(done_at), 128'(v.exp_done));
  endtask

  vec_t  tbl[9];
  tile_t wv;
  vec_t  v;
  int    mode;
  int    t;

  initial begin
    reset       = 1'b1;
    bus.w_valid = 1'b0;
    bus.mac_stall = 1'b0;
    for (int i = 0; i < VL; i++) bus.w_in[i] = '0;

    wv = '0;
    tbl[0] = mk(wv, -1, 0, 1, 4'b1111, 16'h0000, 0, '0, '0, '0);
    for (int i = 0; i < 8; i++) wv[i] = 8'hFF;
    tbl[1] = mk(wv, -1, 0, 1, 4'b1110, 16'h0000, 0, '0, '0, '0);
    wv = '0; wv[0] = 8'd1; wv[7] = 8'd1;
    tbl[2] = mk(wv, -1, 0, 0, '0, '0, 1, 4'b1111, 4'b1001, 12'b100_000_000_000);
    wv = '0; wv[5] = 8'd1; wv[6] = 8'd1; wv[7] = 8'd1;
    tbl[3] = mk(wv, -1, 0, 0, '0, '0, 1, 4'b1111, 4'b1110, 12'b100_100_100_000);
    wv = '0; for (int i = 0; i < 5; i++) wv[i] = 8'd1;
    tbl[4] = mk(wv, -1, 0, 0, '0, '0, 1, 4'b1110, 4'b1110, 12'b100_100_100_000);
    wv = '0; for (int i = 0; i < 4; i++) wv[i] = 8'hFF;
    tbl[5] = mk(wv, -1, 0, 1, 4'b1111, 16'h000F, 0, '0, '0, '0);
    tbl[7] = mk(wv, 7, 2, 1, 4'b1111, 16'h000F, 0, '0, '0, '0);
    for (int i = 0; i < VL; i++) wv[i] = 8'(i * 37 + 5);
    tbl[6] = mk(wv, 4, 3, 0, '0, '0, 0, '0, '0, '0);
    tbl[8] = mk(wv, 0, 1, 0, '0, '0, 0, '0, '0, '0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ctrl", 128'(ctrl_now()), 128'(0));
    check("reset act", 128'({bus.is_skip_zero, bus.act_val, sel_now()}), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle w_ready", 128'({bus.w_ready, bus.busy}), 128'(2'b10));

    for (int n = 0; n < 9; n++) run_tile(tbl[n], $sformatf("vec%0d", n));

    // Reset in the middle of a tile.
    wait_ready("mid_reset");
    bus.w_valid = 1'b1;
    for (int i = 0; i < VL; i++) bus.w_in[i] = tbl[5].w[i];
    @(negedge clk);
    bus.w_valid = 1'b0;
    t = 0;
    while (!(bus.column_idx == 3'd3 && bus.en_acc) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_reset reach col3", 128'(bus.column_idx), 128'(3));
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset ctrl", 128'(ctrl_now()), 128'(0));
    check("mid_reset act", 128'({bus.is_skip_zero, bus.act_val, sel_now()}), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset w_ready", 128'({bus.w_ready, bus.busy}), 128'(2'b10));

    for (int r = 0; r < 24; r++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < VL; i++) begin
        case (mode)
          0: wv[i] = 8'($urandom);
          1: wv[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
          2: wv[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
          default: wv[i] = 8'($urandom_range(0, 7));
        endcase
      end
      v = mk(wv, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 0, '0, '0, 0, '0, '0, '0);
      run_tile(v, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
